// File: rtl/reg_wb_pkg.sv
// reg_wb_pkg: shared widths, entry type and constants for the register writeback controller
package reg_wb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/reg_wb_fifo.sv
// reg_wb_fifo: DEPTH-entry circular buffer of writeback entries, contents exposed for bypass search
module reg_wb_fifo import reg_wb_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input logic Clk,
  input logic Reset_n,
  input logic Push,
  input wb_entry_t PushEntry,
  input logic Pop,
  output wb_entry_t HeadEntry,
  output logic [CNT_W-1:0] Count,
  output logic [PTR_W-1:0] RdPtr,
  output wb_entry_t [DEPTH-1:0] Entries
);
  logic [PTR_W-1:0] wrPtr;
  assign HeadEntry = Entries[RdPtr];
  always_ff @(posedge Clk)
    if (Push) Entries[wrPtr] <= PushEntry;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      wrPtr <= '0;
      RdPtr <= '0;
      Count <= '0;
    end else begin
      if (Push) wrPtr <= wrPtr + PTR_W'(1);
      if (Pop) RdPtr <= RdPtr + PTR_W'(1);
      Count <= Count + CNT_W'(Push) - CNT_W'(Pop);
    end
endmodule

// File: rtl/reg_writeback_ctrl.sv
// reg_writeback_ctrl: queued write port for the MIPS register file with read bypass
// Bypass search is built only when REG_WB_BYPASS_EN is defined; otherwise bypass outputs are 0.
module reg_writeback_ctrl import reg_wb_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input logic Clk,
  input logic Reset_n,
  input logic WbValid,
  output logic WbReady,
  input logic [REG_ADDR_W-1:0] WbRegister,
  input logic [REG_DATA_W-1:0] WbData,
  input logic RfHold,
  output logic RegWrite,
  output logic [REG_ADDR_W-1:0] WriteRegister,
  output logic [REG_DATA_W-1:0] WriteData,
  input logic [REG_ADDR_W-1:0] ReadRegister1,
  input logic [REG_ADDR_W-1:0] ReadRegister2,
  output logic BypassHit1,
  output logic BypassHit2,
  output logic [REG_DATA_W-1:0] BypassData1,
  output logic [REG_DATA_W-1:0] BypassData2,
  output logic [CNT_W-1:0] Pending
);
  logic push, pop;
  wb_entry_t head;
  logic [PTR_W-1:0] rdPtr;
  wb_entry_t [DEPTH-1:0] entries;
  assign WbReady = Pending != CNT_W'(DEPTH);
  // $zero writes complete the handshake but are never queued
  assign push = WbValid && WbReady && WbRegister != REG_ZERO;
  assign pop = !RfHold && Pending != '0;
  reg_wb_fifo #(.DEPTH(DEPTH)) fifo (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .Push(push),
    .PushEntry({WbRegister, WbData}),
    .Pop(pop),
    .HeadEntry(head),
    .Count(Pending),
    .RdPtr(rdPtr),
    .Entries(entries)
  );
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      RegWrite <= 1'b0;
      WriteRegister <= '0;
      WriteData <= '0;
    end else begin
      RegWrite <= pop;
      if (pop) {WriteRegister, WriteData} <= head;
    end
`ifdef REG_WB_BYPASS_EN
  // Oldest to newest: output stage, then queue head to tail; later matches override
  function automatic logic [REG_DATA_W:0] search(input logic [REG_ADDR_W-1:0] a);
    logic [REG_DATA_W:0] r;
    logic [PTR_W-1:0] idx;
    r = RegWrite && WriteRegister == a ? {1'b1, WriteData} : '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rdPtr + PTR_W'(i);
      if (CNT_W'(i) < Pending && entries[idx].addr == a) r = {1'b1, entries[idx].data};
    end
    return a == REG_ZERO ? '0 : r;
  endfunction
  always_comb {BypassHit1, BypassData1} = search(ReadRegister1);
  always_comb {BypassHit2, BypassData2} = search(ReadRegister2);
`else
  logic unusedBypass;
  assign unusedBypass = ^{ReadRegister1, ReadRegister2, entries, rdPtr};
  assign {BypassHit1, BypassData1} = '0;
  assign {BypassHit2, BypassData2} = '0;
`endif
endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// tb_reg_writeback_ctrl: directed stimulus with a write scoreboard checked by an independent monitor
module tb_reg_writeback_ctrl;
  logic Clk = 1'b0, Reset_n = 1'b0, WbValid = 1'b0, RfHold = 1'b0;
  logic [4:0] WbRegister = '0, ReadRegister1 = '0, ReadRegister2 = '0;
  logic [31:0] WbData = '0;
  logic WbReady, RegWrite, BypassHit1, BypassHit2;
  logic [4:0] WriteRegister;
  logic [31:0] WriteData, BypassData1, BypassData2;
  logic [2:0] Pending;
  int checks = 0, fails = 0;
  logic [36:0] expQ[$];
`ifdef REG_WB_BYPASS_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  always #5 Clk = ~Clk;

  reg_writeback_ctrl #(.DEPTH(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .WbValid(WbValid), .WbReady(WbReady),
    .WbRegister(WbRegister), .WbData(WbData), .RfHold(RfHold),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .BypassHit1(BypassHit1), .BypassHit2(BypassHit2),
    .BypassData1(BypassData1), .BypassData2(BypassData2), .Pending(Pending)
  );

  task automatic check(input string name, input logic [36:0] act, input logic [36:0] want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [4:0] a, input logic [31:0] d);
    WbValid = 1'b1;
    WbRegister = a;
    WbData = d;
    if (a != 5'd0) expQ.push_back({a, d});
    step();
  endtask

  always @(negedge Clk)
    if (RegWrite) begin
      if (expQ.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL spurious_write: got reg %0d data %h required no write", WriteRegister, WriteData);
      end else check("write", {WriteRegister, WriteData}, expQ.pop_front());
    end

  initial begin
    #2;
    check("rst_regwrite", RegWrite, 1'b0);
    check("rst_wreg", WriteRegister, 5'd0);
    check("rst_wdata", WriteData, 32'd0);
    check("rst_pending", Pending, 3'd0);
    check("rst_ready", WbReady, 1'b1);
    check("rst_hit1", BypassHit1, 1'b0);
    Reset_n = 1'b1;
    step();
    send(5'd5, 32'hDEADBEEF);
    WbValid = 1'b0;
    check("single_early", RegWrite, 1'b0);
    check("single_pend", Pending, 3'd1);
    step();
    check("single_strobe", RegWrite, 1'b1);
    check("single_addr", WriteRegister, 5'd5);
    check("single_data", WriteData, 32'hDEADBEEF);
    check("single_pend0", Pending, 3'd0);
    step();
    check("single_once", RegWrite, 1'b0);
    send(5'd0, 32'h12345678);
    WbValid = 1'b0;
    check("zero_pend", Pending, 3'd0);
    ReadRegister1 = 5'd0;
    #1;
    check("zero_hit1", BypassHit1, 1'b0);
    step();
    check("zero_nowrite", RegWrite, 1'b0);
    RfHold = 1'b1;
    for (int i = 1; i <= 4; i++) send(5'(i), 32'h100 + i);
    WbValid = 1'b0;
    check("full_ready", WbReady, 1'b0);
    check("full_pend", Pending, 3'd4);
    WbValid = 1'b1;
    WbRegister = 5'd9;
    WbData = 32'h999;
    step();
    WbValid = 1'b0;
    check("full_nopush", Pending, 3'd4);
    RfHold = 1'b0;
    step();
    check("full_pop1", RegWrite, 1'b1);
    check("full_pend3", Pending, 3'd3);
    check("full_ready_back", WbReady, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("full_consec", RegWrite, 1'b1);
    end
    step();
    check("full_done", RegWrite, 1'b0);
    RfHold = 1'b1;
    ReadRegister1 = 5'd3;
    ReadRegister2 = 5'd7;
    send(5'd7, 32'h1);
    check("bp_first_hit", BypassHit2, BP);
    check("bp_first_data", BypassData2, BP ? 32'h1 : 32'h0);
    send(5'd7, 32'h2);
    WbValid = 1'b0;
    check("bp_new_hit", BypassHit2, BP);
    check("bp_new_data", BypassData2, BP ? 32'h2 : 32'h0);
    check("bp_miss1", BypassHit1, 1'b0);
    RfHold = 1'b0;
    step();
    check("bp_mixed_data", BypassData2, BP ? 32'h2 : 32'h0);
    step();
    check("bp_out_hit", BypassHit2, BP);
    check("bp_out_data", BypassData2, BP ? 32'h2 : 32'h0);
    step();
    check("bp_drained_hit", BypassHit2, 1'b0);
    check("bp_drained_data", BypassData2, 32'h0);
    for (int i = 1; i <= 10; i++) begin
      send(5'(i), 32'hA000 + i);
      check("stream_pend", Pending <= 3'd1, 1'b1);
      if (i > 1) check("stream_strobe", RegWrite, 1'b1);
    end
    WbValid = 1'b0;
    step();
    check("stream_last", RegWrite, 1'b1);
    check("stream_pend0", Pending, 3'd0);
    step();
    RfHold = 1'b1;
    send(5'd11, 32'hB1);
    send(5'd12, 32'hB2);
    send(5'd13, 32'hB3);
    WbValid = 1'b0;
    check("mrst_pend", Pending, 3'd3);
    RfHold = 1'b0;
    step();
    check("mrst_strobe", RegWrite, 1'b1);
    expQ.delete();
    #1 Reset_n = 1'b0;
    #1;
    check("mrst_regwrite", RegWrite, 1'b0);
    check("mrst_pend0", Pending, 3'd0);
    check("mrst_wreg", WriteRegister, 5'd0);
    #1 Reset_n = 1'b1;
    check("mrst_ready", WbReady, 1'b1);
    for (int i = 0; i < 4; i++) step();
    check("mrst_nostale", Pending, 3'd0);
    for (int n = 0; n < 20 && expQ.size() != 0; n++) step();
    check("drained", expQ.size() == 0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
